// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default line parameters,
// data width, receiver state type and the 3-sample majority voter.
// UART_RX_PARITY_EN adds the PARITY state to the state type.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BAUD_RATE_DEF  = 115200;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running sample-tick divider: one-clock tick every DIV clocks,
// counter runs 0..DIV-1 and the tick fires on the last count.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // wrap at the last count, otherwise step by one
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // divider counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop rxd synchronizer, majority-voted mid-bit
// sampling, 8 data bits LSB first, frame resolved at the middle of the stop
// bit. Define UART_RX_PARITY_EN for an even-parity bit after the data bits;
// otherwise the frame is 8N1 and parity_err is tied low.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] S_LO  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] S_MID = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] S_HI  = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] S_END = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] B_END = BCW'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

  logic rxd_meta_q, rxd_sync_q;

  // two-flop synchronizer, idles high out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic                 armed_q, armed_d;
  logic [SCW-1:0]       scnt_q, scnt_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 s_lo_q, s_lo_d, s_mid_q, s_mid_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 fe_q, fe_d, ov_q, ov_d;
  logic                 vote;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d, pe_q, pe_d;
`endif

  // voted bit value, meaningful at the third sample point
  assign vote = maj3(s_lo_q, s_mid_q, rxd_sync_q);

  // receiver FSM: all transitions on sample ticks, resolution at mid-stop
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    s_lo_d     = s_lo_q;
    s_mid_d    = s_mid_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    fe_d       = 1'b0;
    ov_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = 1'b0;
`endif
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (tick) begin
      if (state_q != ST_IDLE) begin
        if (scnt_q == S_LO)  s_lo_d  = rxd_sync_q;
        if (scnt_q == S_MID) s_mid_d = rxd_sync_q;
        scnt_d = (scnt_q == S_END) ? '0 : scnt_q + SCW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (rxd_sync_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = ST_START;
            scnt_d  = '0;
            armed_d = 1'b0;
          end
        end
        ST_START: begin
          if (scnt_q == S_HI && vote) begin
            state_d = ST_IDLE;
          end else if (scnt_q == S_END) begin
            state_d = ST_DATA;
            bcnt_d  = '0;
          end
        end
        ST_DATA: begin
          if (scnt_q == S_HI) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (scnt_q == S_END) begin
            if (bcnt_q == B_END) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (scnt_q == S_HI)  par_d   = vote;
          if (scnt_q == S_END) state_d = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (scnt_q == S_HI) begin
            state_d = ST_IDLE;
            // a consumer taking the old byte this same clock frees the slot
            if (!vote) begin
              fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_q != ^shreg_q) begin
              pe_d = 1'b1;
`endif
            end else if (rx_valid_q && !rx_ready) begin
              ov_d = 1'b1;
            end else begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      s_lo_q     <= 1'b0;
      s_mid_q    <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      s_lo_q     <= s_lo_d;
      s_mid_q    <= s_mid_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity sample and parity error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
